alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, pipelined successor to the single-stage ALU. It uses the same a_en/b_en/a_op/b_op decode and generalises data width and pipeline depth. It adds valid/ready handshakes on input and output, an explicit illegal-op error flag and backpressure handling. It sits between the operand sequencer and the result consumer in the ALU datapath.

Parameters:
DATA_WIDTH, 5, operand width; result width is DATA_WIDTH+1
STAGES, 2, pipeline depth and input-to-output latency in cycles; legal range 1..8
CNT_WIDTH, 8, width of the error counter (used only with ALU_ERR_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ALU_en  in  1  global enable; 0 freezes the whole pipeline
in_valid  in  1  operand/opcode beat valid
in_ready  out  1  block can accept a beat
A  in  DATA_WIDTH  signed operand A
B  in  DATA_WIDTH  signed operand B
a_en  in  1  A-group opcode enable
b_en  in  1  B-group opcode enable
a_op  in  3  A-group opcode
b_op  in  2  B-group opcode
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
C  out  DATA_WIDTH+1  signed result
err  out  1  beat carried an illegal or empty opcode
err_cnt  out  CNT_WIDTH  saturating illegal-op count (ALU_ERR_CNT_EN only)

Behaviour:
- Reset (async, rst_n=0): all stage valid bits cleared, out_valid=0, C=0, err=0, err_cnt=0. in_ready is combinational and may read 1 during reset; beats presented in that window are not captured.
- Advance condition: adv = ALU_en && (!out_valid || out_ready).
  - The whole pipeline shifts only when adv=1 (global stall, no bubbles collapsed).
  - in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
- ALU_en=0: no shift; C, err and out_valid hold every bit; in_ready=0.
- Latency: an accepted beat appears at the output exactly STAGES adv-cycles later. Order is preserved. Throughput is 1 beat/cycle with no stall.
- Decode for a_en=1, b_en=0:
  - a_op 0 add; 1 A-B; 2 xor; 3 and; 4 and; 5 or; 6 xnor; 7 illegal.
- Decode for a_en=0, b_en=1:
  - b_op 0 nand; 1 add; 2 add; 3 illegal.
- Decode for a_en=1, b_en=1:
  - b_op 0 xor; 1 xnor; 2 A-1; 3 B+2.
- Decode for a_en=0, b_en=0: illegal (empty op).
- Width rules:
  - Operands are sign-extended to DATA_WIDTH+1 before every op, so arithmetic never overflows.
  - Logical ops are computed on the sign-extended operands.
  - Nand result is zero-extended: {1'b0, ~(A&B)}.
- Illegal beat: still flows through the pipe and produces out_valid=1, err=1. C keeps its last legal value instead of updating.
- Output register:
  - When the last stage fires into the output with adv=1, out_valid takes that stage's valid.
  - C updates only for legal valid beats; err is updated with each valid beat.
  - out_valid drops to 0 when the consumer takes a beat and no new beat arrives behind it.
- Simultaneous out_ready and a new beat at the last stage: the old beat is consumed and the new one is loaded in the same cycle.
- Reset mid-operation: all in-flight beats are discarded. No output beat from them appears after rst_n rises.

Optional Feature:
ALU_ERR_CNT_EN:
- Defined: err_cnt increments on each output handshake (out_valid && out_ready) with err=1. It saturates at 2^CNT_WIDTH-1 and resets to 0.
- Undefined: the err_cnt port and counter are absent; everything else is identical.

Decomposition:
- alu_pipe_pkg holds:
  - the op_e enum (ADD, SUB, XOR, AND, OR, XNOR, NAND, DEC1, INC2, ILLEGAL);
  - the stage struct {valid, op_e, A, B};
  - a decode function mapping a_en/b_en/a_op/b_op to op_e.
- One combinational sub-module, alu_pipe_exec, computes C from op_e, A and B. The top instantiates it at the final stage; earlier stages only carry decoded beats.

Test Plan (DATA_WIDTH=5, STAGES=2):
- Add: a_en=1, b_en=0, a_op=0, A=7, B=5, accepted at cycle t -> out_valid=1 at t+2, C=12, err=0.
- Negative sub: a_op=1, A=-16, B=15 -> C=-31 (6'b100001), err=0.
- Nand: a_en=0, b_en=1, b_op=0, A=5'b10101, B=5'b11100 -> C=6'b001011 (11).
- Illegal after add: C=12, then a_op=7 -> out_valid=1, err=1, C stays 12. With ALU_ERR_CNT_EN, err_cnt goes 0->1 on handshake.
- Backpressure: pipe full, out_ready=0 for 3 cycles -> in_ready=0, C/err/out_valid stable. On out_ready=1, beats drain in order, one per cycle.
- Freeze/reset: ALU_en=0 for 4 cycles -> all outputs hold. Then rst_n=0 with 2 beats in flight -> out_valid=0, C=0 immediately, and no beats emerge after release.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: decoded opcode enum, opcode field widths and the opcode decoder.
package alu_pipe_pkg;

    localparam int unsigned A_OP_W = 3;
    localparam int unsigned B_OP_W = 2;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_XOR,
        OP_AND,
        OP_OR,
        OP_XNOR,
        OP_NAND,
        OP_DEC1,
        OP_INC2,
        OP_ILLEGAL
    } op_e;

    // Maps the raw enable/opcode fields onto one decoded operation.
    function automatic op_e decode_op(input logic              a_en,
                                      input logic              b_en,
                                      input logic [A_OP_W-1:0] a_op,
                                      input logic [B_OP_W-1:0] b_op);
        op_e op;
        op = OP_ILLEGAL;
        case ({a_en, b_en})
            2'b10: begin
                case (a_op)
                    3'd0:    op = OP_ADD;
                    3'd1:    op = OP_SUB;
                    3'd2:    op = OP_XOR;
                    3'd3:    op = OP_AND;
                    3'd4:    op = OP_AND;
                    3'd5:    op = OP_OR;
                    3'd6:    op = OP_XNOR;
                    default: op = OP_ILLEGAL;
                endcase
            end
            2'b01: begin
                case (b_op)
                    2'd0:    op = OP_NAND;
                    2'd1:    op = OP_ADD;
                    2'd2:    op = OP_ADD;
                    default: op = OP_ILLEGAL;
                endcase
            end
            2'b11: begin
                case (b_op)
                    2'd0:    op = OP_XOR;
                    2'd1:    op = OP_XNOR;
                    2'd2:    op = OP_DEC1;
                    default: op = OP_INC2;
                endcase
            end
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; err_cnt exists only with ALU_ERR_CNT_EN.
interface alu_pipe_if
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 5
`ifdef ALU_ERR_CNT_EN
    , parameter int unsigned CNT_WIDTH = 8
`endif
);
    logic                         ALU_en;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] A;
    logic signed [DATA_WIDTH-1:0] B;
    logic                         a_en;
    logic                         b_en;
    logic [A_OP_W-1:0]            a_op;
    logic [B_OP_W-1:0]            b_op;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH:0]   C;
    logic                         err;
`ifdef ALU_ERR_CNT_EN
    logic [CNT_WIDTH-1:0]         err_cnt;
`endif

    modport slave (
        input  ALU_en, in_valid, A, B, a_en, b_en, a_op, b_op, out_ready,
        output in_ready, out_valid, C, err
`ifdef ALU_ERR_CNT_EN
        , output err_cnt
`endif
    );

    modport master (
        output ALU_en, in_valid, A, B, a_en, b_en, a_op, b_op, out_ready,
        input  in_ready, out_valid, C, err
`ifdef ALU_ERR_CNT_EN
        , input err_cnt
`endif
    );

endinterface

// File: rtl/alu_pipe_exec.sv
// Combinational ALU core: evaluates one decoded op on sign-extended operands.
module alu_pipe_exec
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 5
) (
    input  op_e                          i_op,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH:0]   o_result_c
);
    localparam int unsigned RW = DATA_WIDTH + 1;

    logic signed [DATA_WIDTH:0] w_a;
    logic signed [DATA_WIDTH:0] w_b;

    assign w_a = {i_a[DATA_WIDTH-1], i_a};
    assign w_b = {i_b[DATA_WIDTH-1], i_b};

    always_comb begin
        o_result_c = '0;
        case (i_op)
            OP_ADD:  o_result_c = w_a + w_b;
            OP_SUB:  o_result_c = w_a - w_b;
            OP_XOR:  o_result_c = w_a ^ w_b;
            OP_AND:  o_result_c = w_a & w_b;
            OP_OR:   o_result_c = w_a | w_b;
            OP_XNOR: o_result_c = ~(w_a ^ w_b);
            // Nand is the one op whose result is zero- rather than sign-extended.
            OP_NAND: o_result_c = {1'b0, ~(i_a & i_b)};
            OP_DEC1: o_result_c = w_a - RW'(1);
            OP_INC2: o_result_c = w_b + RW'(2);
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with global-stall valid/ready handshakes and illegal-op flag.
// Define ALU_ERR_CNT_EN to add the saturating err_cnt output.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned STAGES     = 2
`ifdef ALU_ERR_CNT_EN
    , parameter int unsigned CNT_WIDTH = 8
`endif
) (
    input logic      clk,
    input logic      rst_n,
    alu_pipe_if.slave bus
);
    typedef struct packed {
        logic                         valid;
        op_e                          op;
        logic signed [DATA_WIDTH-1:0] a;
        logic signed [DATA_WIDTH-1:0] b;
    } stage_t;

    logic                       w_adv;
    stage_t                     w_in;
    stage_t                     w_last;
    logic signed [DATA_WIDTH:0] w_c;

    logic                       r_out_valid;
    logic signed [DATA_WIDTH:0] r_c;
    logic                       r_err;

    // Whole pipe moves in lockstep; the output register counts as the last stage.
    assign w_adv        = bus.ALU_en && (!r_out_valid || bus.out_ready);
    assign bus.in_ready = w_adv;

    always_comb begin
        w_in       = '0;
        w_in.valid = bus.in_valid;
        w_in.op    = decode_op(bus.a_en, bus.b_en, bus.a_op, bus.b_op);
        w_in.a     = bus.A;
        w_in.b     = bus.B;
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign w_last = w_in;
        end else begin : g_pipe
            stage_t r_stage [STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < STAGES - 1; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_stage[0] <= w_in;
                    for (int unsigned i = 1; i < STAGES - 1; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_last = r_stage[STAGES-2];
        end
    endgenerate

    alu_pipe_exec #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_exec (
        .i_op       (w_last.op),
        .i_a        (w_last.a),
        .i_b        (w_last.b),
        .o_result_c (w_c)
    );

    // Illegal beats still emerge with err set, but leave C at its last legal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_err       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_last.valid;
            if (w_last.valid) begin
                r_err <= (w_last.op == OP_ILLEGAL);
                if (w_last.op != OP_ILLEGAL) begin
                    r_c <= w_c;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.C         = r_c;
    assign bus.err       = r_err;

`ifdef ALU_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_err_cnt;

    // Counts consumed error beats; a frozen pipe (ALU_en=0) consumes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.ALU_en && r_out_valid && bus.out_ready && r_err
                     && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised + directed scoreboard bench for alu_pipe (DATA_WIDTH=5, STAGES=2).
module tb_alu_pipe;

    localparam int DW = 5;

    typedef struct {
        logic       err;
        logic [5:0] c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_pipe_if #(.DATA_WIDTH(DW)) bus ();

    alu_pipe #(
        .DATA_WIDTH (DW),
        .STAGES     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    logic [5:0] model_c = 6'd0;
    int         total   = 0;
    int         bad     = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference: the decode table evaluated with plain integer arithmetic.
    function automatic void ref_model(input logic ae, input logic be,
                                      input logic [2:0] aop, input logic [1:0] bop,
                                      input logic [4:0] a, input logic [4:0] b,
                                      output logic ill, output logic [5:0] r);
        int ia;
        int ib;
        int v;
        ia  = int'($signed(a));
        ib  = int'($signed(b));
        v   = 0;
        ill = 1'b0;
        if (ae && !be) begin
            case (aop)
                3'd0: v = ia + ib;
                3'd1: v = ia - ib;
                3'd2: v = ia ^ ib;
                3'd3: v = ia & ib;
                3'd4: v = ia & ib;
                3'd5: v = ia | ib;
                3'd6: v = ~(ia ^ ib);
                default: ill = 1'b1;
            endcase
        end else if (!ae && be) begin
            case (bop)
                2'd0: v = (~(ia & ib)) & 31;
                2'd1: v = ia + ib;
                2'd2: v = ia + ib;
                default: ill = 1'b1;
            endcase
        end else if (ae && be) begin
            case (bop)
                2'd0: v = ia ^ ib;
                2'd1: v = ~(ia ^ ib);
                2'd2: v = ia - 1;
                default: v = ib + 2;
            endcase
        end else begin
            ill = 1'b1;
        end
        r = v[5:0];
    endfunction

    // Scoreboard: pop on each consumed output beat, push on each accepted input beat.
    always @(negedge clk) begin
        exp_t       e;
        logic       ill;
        logic [5:0] r;
        if (!rst_n) begin
            exp_q.delete();
            model_c = 6'd0;
        end else begin
            if (bus.ALU_en && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_err", {31'd0, bus.err}, {31'd0, e.err});
                    chk("sb_c", {26'd0, $unsigned(bus.C)}, {26'd0, e.c});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_model(bus.a_en, bus.b_en, bus.a_op, bus.b_op, bus.A, bus.B, ill, r);
                if (!ill) model_c = r;
                e.err = ill;
                e.c   = model_c;
                exp_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic ae, input logic be, input logic [2:0] aop,
                         input logic [1:0] bop, input logic [4:0] a, input logic [4:0] b);
        bus.a_en = ae;
        bus.b_en = be;
        bus.a_op = aop;
        bus.b_op = bop;
        bus.A    = a;
        bus.B    = b;
    endtask

    task automatic drive_rand();
        drive(1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
    endtask

    // One isolated beat: checks two-cycle latency and the directed result value.
    task automatic one_beat(input string nm, input logic ae, input logic be,
                            input logic [2:0] aop, input logic [1:0] bop,
                            input logic [4:0] a, input logic [4:0] b,
                            input logic [5:0] want_c, input logic want_err);
        @(posedge clk); #1;
        bus.ALU_en    = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(ae, be, aop, bop, a, b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk({nm, "_lat2"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_c"}, {26'd0, $unsigned(bus.C)}, {26'd0, want_c});
        chk({nm, "_err"}, {31'd0, bus.err}, {31'd0, want_err});
    endtask

    initial begin
        logic [5:0] hold_c;
        logic       hold_err;
        bit         stalled;

        bus.ALU_en    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 5'd0);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_c", {26'd0, $unsigned(bus.C)}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        one_beat("add", 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 5'd5, 6'd12, 1'b0);
        one_beat("sub_neg", 1'b1, 1'b0, 3'd1, 2'd0, 5'b10000, 5'b01111, 6'b100001, 1'b0);
        one_beat("nand", 1'b0, 1'b1, 3'd0, 2'd0, 5'b10101, 5'b11100, 6'b001011, 1'b0);
        one_beat("add2", 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 5'd5, 6'd12, 1'b0);
        one_beat("illegal", 1'b1, 1'b0, 3'd7, 2'd0, 5'd3, 5'd9, 6'd12, 1'b1);
        one_beat("empty_op", 1'b0, 1'b0, 3'd0, 2'd0, 5'd1, 5'd1, 6'd12, 1'b1);
        one_beat("inc2", 1'b1, 1'b1, 3'd0, 2'd3, 5'd0, 5'b01111, 6'd17, 1'b0);

        // Backpressure: fill until in_ready drops, hold three cycles, then drain.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(1'b1, 1'b0, 3'($urandom_range(0, 6)), 2'd0, 5'($urandom), 5'($urandom));
        stalled = 1'b0;
        for (int i = 0; i < 10 && !stalled; i++) begin
            @(posedge clk); #1;
            if (!bus.in_ready) stalled = 1'b1;
            else drive(1'b1, 1'b0, 3'($urandom_range(0, 6)), 2'd0, 5'($urandom), 5'($urandom));
        end
        chk("bp_stall_reached", {31'd0, stalled}, 32'd1);
        hold_c   = bus.C;
        hold_err = bus.err;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_valid_hold", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_c_hold", {26'd0, $unsigned(bus.C)}, {26'd0, hold_c});
            chk("bp_err_hold", {31'd0, bus.err}, {31'd0, hold_err});
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain_beat1", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        chk("drain_beat2", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

        // Freeze with two known beats in flight, then reset them away.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 5'd4);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 2'd0, 5'd2, 5'd2);
        @(posedge clk); #1;
        bus.ALU_en    = 1'b0;
        bus.out_ready = 1'b1;
        hold_c   = bus.C;
        hold_err = bus.err;
        chk("frz_c_seen", {26'd0, $unsigned(bus.C)}, 32'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("frz_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("frz_c", {26'd0, $unsigned(bus.C)}, {26'd0, hold_c});
            chk("frz_err", {31'd0, bus.err}, {31'd0, hold_err});
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom);
            drive_rand();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_c", {26'd0, $unsigned(bus.C)}, 32'd0);
        chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n         = 1'b1;
        bus.ALU_en    = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
        end

        // Random traffic with random enable and backpressure.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.ALU_en    = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_valid  = 1'($urandom);
            drive_rand();
        end

        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.ALU_en    = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("final_drain", exp_q.size(), 32'd0);
        chk("final_idle", {31'd0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
